// File: rtl/fall_detect_core.sv
// Fall detector: decimated 3-axis samples -> squared SVM (2-stage pipe) -> free-fall/impact/alarm FSM.
// svm_valid 2 cycles after the tick cycle, state/alarm 3 cycles after; free-running, no backpressure.
module fall_detect_core #(
  parameter int DW          = 16,
  parameter int SAMPLE_DIV  = 524288,
  parameter int IMPACT_WIN  = 8,
  parameter int CONFIRM_N   = 2,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic signed [DW-1:0] ax,
  input  logic signed [DW-1:0] ay,
  input  logic signed [DW-1:0] az,
  input  logic signed [DW-1:0] t_lowg,
  input  logic [2*DW-1:0]      t_svm,
  output logic                 alarm,
  output logic [2:0]           state_o,
  output logic [2*DW-1:0]      svm_o,
  output logic                 svm_valid,
  output logic [7:0]           fall_count
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int WW = $clog2(IMPACT_WIN + 1);
  localparam int CW = $clog2(CONFIRM_N + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_ALARM = 3'd2
  } state_t;

  state_t                 state;
  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic signed [2*DW-1:0] ax_e, ay_e, az_e;
  logic [2*DW-1:0]        sq_x, sq_y, sq_z;
  logic signed [DW-1:0]   az_d, az_s;
  logic                   sq_vld;
  logic [WW-1:0]          win_cnt;
  logic [CW-1:0]          hit_cnt;
  logic [HW-1:0]          hold_cnt;
  logic                   hit;
  logic                   freefall;

  assign tick    = enable && (tick_cnt == TW'(SAMPLE_DIV - 1));
  assign state_o = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign ax_e = {{DW{ax[DW-1]}}, ax};
  assign ay_e = {{DW{ay[DW-1]}}, ay};
  assign az_e = {{DW{az[DW-1]}}, az};

  // Squares fit in 2*DW bits even for the most negative input, so the sum cannot wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_x      <= '0;
      sq_y      <= '0;
      sq_z      <= '0;
      az_d      <= '0;
      az_s      <= '0;
      sq_vld    <= 1'b0;
      svm_o     <= '0;
      svm_valid <= 1'b0;
    end else begin
      sq_vld    <= tick;
      svm_valid <= enable && sq_vld;
      if (tick) begin
        sq_x <= $unsigned(ax_e * ax_e);
        sq_y <= $unsigned(ay_e * ay_e);
        sq_z <= $unsigned(az_e * az_e);
        az_d <= az;
      end
      if (sq_vld) begin
        svm_o <= sq_x + sq_y + sq_z;
        az_s  <= az_d;
      end
    end
  end

  assign hit      = svm_o > t_svm;
  assign freefall = !az_s[DW-1] && (az_s != '0) && (az_s < t_lowg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      win_cnt    <= '0;
      hit_cnt    <= '0;
      hold_cnt   <= '0;
      alarm      <= 1'b0;
      fall_count <= '0;
    end else if (!enable) begin
      state    <= S_IDLE;
      win_cnt  <= '0;
      hit_cnt  <= '0;
      hold_cnt <= '0;
      alarm    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (svm_valid && freefall) begin
            state   <= S_ARMED;
            win_cnt <= WW'(IMPACT_WIN);
            hit_cnt <= '0;
          end
        end
        S_ARMED: begin
          if (svm_valid) begin
            // Confirmation is tested before the window timeout so the last window sample can still alarm.
            if (hit && (hit_cnt == CW'(CONFIRM_N - 1))) begin
              state    <= S_ALARM;
              alarm    <= 1'b1;
              hold_cnt <= '0;
              hit_cnt  <= '0;
              if (fall_count != 8'hFF) begin
                fall_count <= fall_count + 1'b1;
              end
            end else begin
              hit_cnt <= hit ? hit_cnt + 1'b1 : '0;
              win_cnt <= win_cnt - 1'b1;
              if (win_cnt == WW'(1)) begin
                state <= S_IDLE;
              end
            end
          end
        end
        S_ALARM: begin
          if (clear || (hold_cnt == HW'(HOLD_CYCLES - 1))) begin
            state    <= S_IDLE;
            alarm    <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule
